// File: rtl/loader_sdram_sched.sv
// SDRAM port-A scheduler: queues ROM-loader bytes and writes them one per NES cycle.
// The CPU gets the port whenever the loader has nothing queued or in flight.
module loader_sdram_sched #(
    parameter int DEPTH = 4,
    parameter int AW    = 22
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    nes_ce,
    input  logic          load_mode,
    input  logic          ld_wr,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_read,
    input  logic          cpu_write,
    input  logic [7:0]    cpu_dout,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic          mem_oe,
    output logic [7:0]    mem_din,
    output logic          sel_loader,
    output logic          fifo_full,
    output logic          overflow
);

    // state | meaning
    // IDLE  | nothing was popped at the last phase-3 edge
    // WRITE | head was popped into the staging register; it drives the port next NES cycle

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int EW = AW + 8;

    typedef enum logic {IDLE, WRITE} state_t;

    logic [EW-1:0] fifo_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    state_t        state_q;
    logic [EW-1:0] stg_q;
    logic [EW-1:0] wr_q;
    logic          sched_we_q;

    logic          pop;
    logic          push;
    logic          full;
    logic          wr_active;

    always_comb begin
        full       = (count_q == CW'(DEPTH));
        pop        = (nes_ce == 2'd3) && (count_q != '0);
        push       = ld_wr && (!full || pop);
        count_d    = count_q + CW'(push) - CW'(pop);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        wr_ptr_d   = wr_ptr_q + PW'(push);
        overflow_d = overflow_q | (ld_wr && full && !pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {ld_addr, ld_data};
        end
    end

    // The popped byte is presented during phases 3,0,1,2 of the following NES cycle,
    // so the staging register frees up at the same edge that picks the next byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            stg_q      <= '0;
            wr_q       <= '0;
            sched_we_q <= 1'b0;
        end else begin
            if (nes_ce == 2'd3) begin
                if (count_q != '0) begin
                    state_q <= WRITE;
                    stg_q   <= fifo_q[rd_ptr_q];
                end else begin
                    state_q <= IDLE;
                end
            end
            if (nes_ce == 2'd2) begin
                sched_we_q <= (state_q == WRITE);
                wr_q       <= stg_q;
            end
        end
    end

    always_comb begin
        wr_active  = (state_q == WRITE) || sched_we_q;
        sel_loader = load_mode || (count_q != '0) || wr_active;
        fifo_full  = full;
        overflow   = overflow_q;
        mem_addr   = cpu_addr;
        mem_din    = cpu_dout;
        mem_we     = cpu_write;
        mem_oe     = cpu_read;
        if (sel_loader) begin
            mem_addr = wr_q[EW-1:8];
            mem_din  = wr_q[7:0];
            mem_we   = sched_we_q;
            mem_oe   = 1'b0;
        end
    end

endmodule

// File: tb/tb_loader_sdram_sched.sv
// Bench for loader_sdram_sched: directed scenarios plus random traffic against a
// timeline model (queue of bytes, list of 4-clk write windows).
module tb_loader_sdram_sched;

    localparam int DEPTH = 4;
    localparam int AW    = 22;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    nes_ce;
    logic          load_mode;
    logic          ld_wr;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_data;
    logic [AW-1:0] cpu_addr;
    logic          cpu_read;
    logic          cpu_write;
    logic [7:0]    cpu_dout;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic          mem_oe;
    logic [7:0]    mem_din;
    logic          sel_loader;
    logic          fifo_full;
    logic          overflow;

    always #5 clk = ~clk;

    loader_sdram_sched #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .nes_ce(nes_ce), .load_mode(load_mode),
        .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data),
        .cpu_addr(cpu_addr), .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_dout(cpu_dout),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_oe(mem_oe), .mem_din(mem_din),
        .sel_loader(sel_loader), .fifo_full(fifo_full), .overflow(overflow)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct { logic [AW-1:0] a; logic [7:0] d; } entry_t;
    typedef struct { int start; logic [AW-1:0] a; logic [7:0] d; } win_t;

    entry_t q[$];
    win_t   wins[$];
    bit     m_ovf = 0;
    int     n = 0;
    int     ce = 0;
    int     pops = 0;

    logic          obs_we, obs_oe, obs_sel, obs_full, prev_we;
    logic [AW-1:0] obs_addr;
    logic [7:0]    obs_din;
    int            we_cnt, first_we, last_we, saw_full;
    logic [AW-1:0] we_addrs[$];

    task automatic clear_mon();
        we_cnt = 0; first_we = -1; last_we = -1; saw_full = 0;
        we_addrs.delete();
    endtask

    // One clock: check outputs against the model, then advance the model across the edge.
    task automatic tick();
        bit     act, esel;
        entry_t e;
        win_t   w;
        nes_ce = 2'(ce);
        @(negedge clk);
        while (wins.size() > 0 && wins[0].start + 3 < n) void'(wins.pop_front());
        act  = (wins.size() > 0) && (wins[0].start <= n);
        esel = load_mode || (q.size() > 0) || (wins.size() > 0);
        obs_we = mem_we; obs_oe = mem_oe; obs_sel = sel_loader; obs_full = fifo_full;
        obs_addr = mem_addr; obs_din = mem_din;
        if (obs_we === 1'b1) begin
            we_cnt++;
            if (first_we < 0) first_we = n;
            last_we = n;
            if (prev_we !== 1'b1 || (act && wins[0].start == n)) we_addrs.push_back(obs_addr);
        end
        if (obs_full === 1'b1) saw_full = 1;
        prev_we = obs_we;
        check_val("sel_loader", sel_loader, esel);
        check_val("fifo_full", fifo_full, q.size() == DEPTH);
        check_val("overflow", overflow, m_ovf);
        if (esel) begin
            check_val("mem_we", mem_we, act);
            check_val("mem_oe", mem_oe, 0);
            if (act) begin
                check_val("mem_addr", mem_addr, wins[0].a);
                check_val("mem_din", mem_din, wins[0].d);
            end
        end else begin
            check_val("cpu_we", mem_we, cpu_write);
            check_val("cpu_oe", mem_oe, cpu_read);
            check_val("cpu_addr", mem_addr, cpu_addr);
            check_val("cpu_din", mem_din, cpu_dout);
        end
        if (reset) begin
            q.delete(); wins.delete(); m_ovf = 0;
        end else begin
            if (ce == 3 && q.size() > 0) begin
                e = q.pop_front();
                w.start = n + 4; w.a = e.a; w.d = e.d;
                wins.push_back(w);
                pops++;
            end
            if (ld_wr) begin
                e.a = ld_addr; e.d = ld_data;
                if (q.size() < DEPTH) q.push_back(e);
                else m_ovf = 1;
            end
        end
        @(posedge clk);
        #1;
        n++;
        ce = (ce + 1) % 4;
        ld_wr = 1'b0;
    endtask

    task automatic strobe(input logic [AW-1:0] a, input logic [7:0] d);
        ld_wr = 1'b1; ld_addr = a; ld_data = d;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int lat, fall_n, p0;
        logic [AW-1:0] fa;
        logic [7:0]    fd;

        reset = 1'b1; nes_ce = 2'd0; load_mode = 1'b0; ld_wr = 1'b0;
        ld_addr = '0; ld_data = '0; cpu_addr = '0; cpu_read = 1'b0;
        cpu_write = 1'b0; cpu_dout = '0; prev_we = 1'b0;
        clear_mon();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        tick();

        // single byte, latency from the phase-2 cycle
        load_mode = 1'b1;
        repeat (3) tick();
        while (ce != 2) tick();
        strobe(22'h000010, 8'hA5);
        lat = -1; fa = '0; fd = '0;
        clear_mon();
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (obs_we === 1'b1 && lat < 0) begin
                lat = i; fa = obs_addr; fd = obs_din;
            end
        end
        check_val("latency", lat, 5);
        check_val("we_len", we_cnt, 4);
        check_val("first_addr", fa, 22'h000010);
        check_val("first_din", fd, 8'hA5);

        // four strobes spaced one NES cycle apart
        clear_mon();
        for (int k = 0; k < 4; k++) begin
            strobe(AW'(k), 8'($urandom));
            repeat (3) tick();
        end
        repeat (16) tick();
        check_val("burst_we_cnt", we_cnt, 16);
        check_val("burst_contig", last_we - first_we + 1, 16);
        check_val("burst_windows", we_addrs.size(), 4);
        for (int k = 0; k < 4 && k < we_addrs.size(); k++)
            check_val("burst_order", we_addrs[k], k);
        check_val("burst_ovf", overflow, 0);

        // six back-to-back strobes into a four-deep FIFO
        do_reset();
        clear_mon();
        p0 = pops;
        for (int k = 0; k < 6; k++) strobe(AW'(22'h100 + k), 8'(k + 8'h40));
        repeat (40) tick();
        check_val("ovf_full_seen", saw_full, 1);
        check_val("ovf_sticky", overflow, 1);
        check_val("ovf_writes", we_cnt, 4 * (pops - p0));
        check_val("ovf_4or5", (we_cnt == 16 || we_cnt == 20), 1);
        if (we_addrs.size() > 0) check_val("ovf_first", we_addrs[0], 22'h100);

        // load_mode falls with three bytes queued
        do_reset();
        clear_mon();
        load_mode = 1'b1;
        while (ce != 0) tick();
        for (int k = 0; k < 3; k++) strobe(AW'(22'h200 + k), 8'(k));
        load_mode = 1'b0;
        fall_n = -1;
        for (int i = 0; i < 40 && fall_n < 0; i++) begin
            tick();
            if (obs_sel === 1'b0) fall_n = n - 1;
        end
        check_val("drain_we_cnt", we_cnt, 12);
        check_val("drain_sel_hold", fall_n, last_we + 1);
        cpu_read = 1'b1; cpu_addr = 22'h008000;
        tick();
        check_val("cpu_rd_oe", obs_oe, 1);
        check_val("cpu_rd_addr", obs_addr, 22'h008000);
        cpu_read = 1'b0;

        // CPU write passthrough, same cycle
        cpu_write = 1'b1; cpu_addr = 22'h0000FF; cpu_dout = 8'h3C;
        tick();
        check_val("cpu_wr_we", obs_we, 1);
        check_val("cpu_wr_din", obs_din, 8'h3C);
        check_val("cpu_wr_sel", obs_sel, 0);
        cpu_write = 1'b0;

        // reset in the middle of a write window
        load_mode = 1'b1;
        for (int k = 0; k < 6; k++) strobe(AW'(22'h300 + k), 8'hC0);
        for (int i = 0; i < 20 && obs_we !== 1'b1; i++) tick();
        check_val("rst_pre_we", obs_we, 1);
        load_mode = 1'b0;
        do_reset();
        check_val("rst_we", mem_we, 0);
        check_val("rst_full", fifo_full, 0);
        check_val("rst_ovf", overflow, 0);
        check_val("rst_sel", sel_loader, 0);
        tick();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(49) == 0) load_mode = ~load_mode;
            reset     = ($urandom_range(149) == 0);
            ld_wr     = load_mode ? ($urandom_range(2) == 0) : ($urandom_range(9) == 0);
            ld_addr   = AW'($urandom);
            ld_data   = 8'($urandom);
            cpu_addr  = AW'($urandom);
            cpu_dout  = 8'($urandom);
            cpu_read  = $urandom_range(1) == 0;
            cpu_write = $urandom_range(3) == 0;
            tick();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
